rrobin_client: RTL

RROBIN_CLIENT -- requirements
Module: rrobin_client

---
 rtl/rrobin_client.sv | 130 +++++++++++++
 1 files changed

// File: rtl/rrobin_client.sv
// ============================================================================
// Module   : rrobin_client
// Brief    : Two-channel job client for a two-way arbiter. Pending-job
//            counters, request FSMs, overflow/starvation/protocol flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rrobin_client #(
  parameter int DEPTH_W      = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               job0,
  input  logic               job1,
  input  logic               ack0,
  input  logic               ack1,
  output logic               req0,
  output logic               req1,
  output logic [DEPTH_W-1:0] pend0,
  output logic [DEPTH_W-1:0] pend1,
  output logic               ovf0,
  output logic               ovf1,
  output logic               starve0,
  output logic               starve1,
  output logic               perr
);

  localparam int                   c_WAIT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [DEPTH_W-1:0]   c_PEND_MAX = '1;
  localparam logic [c_WAIT_W-1:0]  c_STARVE   = c_WAIT_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [1:0]         w_job;
  logic [1:0]         w_ack;
  logic [1:0]         w_req;
  logic [1:0]         w_ovf;
  logic [1:0]         w_starve;
  logic [DEPTH_W-1:0] w_pend [2];
  logic               w_perr_hit;
  logic               r_perr;

  assign w_job = {job1, job0};
  assign w_ack = {ack1, ack0};

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    state_t              r_state;
    state_t              w_state_nxt;
    logic [DEPTH_W-1:0]  r_pend;
    logic [DEPTH_W-1:0]  w_pend_nxt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_ovf;
    logic                r_starve;
    logic                w_served;
    logic                w_ovf_hit;

    // An ack only serves a job while this channel's registered request is up.
    assign w_served = w_ack[gi] & (r_state == ST_ACTIVE);

    always_comb begin
      w_pend_nxt  = r_pend;
      w_ovf_hit   = 1'b0;
      w_wait_nxt  = '0;
      if (w_job[gi] && !w_served) begin
        if (r_pend == c_PEND_MAX) begin
          w_ovf_hit = 1'b1;
        end else begin
          w_pend_nxt = r_pend + 1'b1;
        end
      end else if (!w_job[gi] && w_served) begin
        w_pend_nxt = r_pend - 1'b1;
      end
      w_state_nxt = (w_pend_nxt != '0) ? ST_ACTIVE : ST_IDLE;
      if (r_state == ST_ACTIVE && !w_ack[gi]) begin
        w_wait_nxt = (r_wait == c_STARVE) ? r_wait : r_wait + 1'b1;
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= ST_IDLE;
        r_pend   <= '0;
        r_wait   <= '0;
        r_ovf    <= 1'b0;
        r_starve <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_pend   <= w_pend_nxt;
        r_wait   <= w_wait_nxt;
        r_ovf    <= r_ovf | w_ovf_hit;
        r_starve <= r_starve | (w_wait_nxt == c_STARVE);
      end
    end

    assign w_req[gi]    = (r_state == ST_ACTIVE);
    assign w_pend[gi]   = r_pend;
    assign w_ovf[gi]    = r_ovf;
    assign w_starve[gi] = r_starve;
  end

  // Protocol error: both grants at once, or a grant to a channel not requesting.
  assign w_perr_hit = (ack0 & ack1) | (|(w_ack & ~w_req));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= r_perr | w_perr_hit;
    end
  end

  assign req0    = w_req[0];
  assign req1    = w_req[1];
  assign pend0   = w_pend[0];
  assign pend1   = w_pend[1];
  assign ovf0    = w_ovf[0];
  assign ovf1    = w_ovf[1];
  assign starve0 = w_starve[0];
  assign starve1 = w_starve[1];
  assign perr    = r_perr;

endmodule

`default_nettype wire
